// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer and its register slices.
package fetch_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_OPC_W      = 3;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_OPND_SHIFT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    OPER   = 3'd3,
    EXEC   = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_sequencer_param_register.sv
// Width-parametrised load-enable register with asynchronous active-low clear to RST_VAL.
module param_register #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/operand/execute sequencer: owns PC, MAR, IR, MDR, store data, branch latch and show
// register, and runs a req/ready memory handshake plus an exec_req/exec_done execute handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                OPC_W      = DEF_OPC_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                OPND_SHIFT = DEF_OPND_SHIFT,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              need_mem,
  input  logic              is_store,
  input  logic [DATA_W-1:0] a_data,
  output logic              exec_req,
  input  logic              exec_done,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              show_load,
  output logic [DATA_W-1:0] show_out,
  output logic              status,
  output logic              busy
);

  localparam int OPND_W = DATA_W - OPC_W;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d, blatch_q, eff_pc, opnd_addr;
  logic [DATA_W-1:0] ir_q, mdr_q, show_q, wdata_q;
  logic              pc_ld, mar_ld, ir_ld, mdr_ld, show_ld, br_ld, wdata_ld;
  logic              we_q, we_d;
  logic              taken_q, taken_d;

  // A taken branch is held in the branch latch and becomes the PC lazily; the stored PC
  // is only rewritten on the next fetch completion.
  assign eff_pc = taken_q ? blatch_q : pc_q;

  assign operand = {{OPC_W{1'b0}}, ir_q[OPND_W-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_opnd_addr
      if ((gi >= OPND_SHIFT) && ((gi - OPND_SHIFT) < DATA_W)) begin : g_bit
        assign opnd_addr[gi] = operand[gi-OPND_SHIFT];
      end else begin : g_zero
        assign opnd_addr[gi] = 1'b0;
      end
    end
  endgenerate

  param_register #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(reset_n), .load(pc_ld), .d(pc_d), .q(pc_q)
  );
  param_register #(.W(ADDR_W)) u_mar (
    .clk(clk), .rst_n(reset_n), .load(mar_ld), .d(mar_d), .q(mar_q)
  );
  param_register #(.W(DATA_W)) u_ir (
    .clk(clk), .rst_n(reset_n), .load(ir_ld), .d(mem_rdata), .q(ir_q)
  );
  param_register #(.W(DATA_W)) u_mdr (
    .clk(clk), .rst_n(reset_n), .load(mdr_ld), .d(mem_rdata), .q(mdr_q)
  );
  param_register #(.W(DATA_W)) u_show (
    .clk(clk), .rst_n(reset_n), .load(show_ld), .d(mdr_q), .q(show_q)
  );
  param_register #(.W(ADDR_W)) u_blatch (
    .clk(clk), .rst_n(reset_n), .load(br_ld), .d(branch_target), .q(blatch_q)
  );
  param_register #(.W(DATA_W)) u_wdata (
    .clk(clk), .rst_n(reset_n), .load(wdata_ld), .d(a_data), .q(wdata_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    taken_d  = taken_q;
    pc_d     = eff_pc + ADDR_W'(1);
    mar_d    = eff_pc;
    pc_ld    = 1'b0;
    mar_ld   = 1'b0;
    ir_ld    = 1'b0;
    mdr_ld   = 1'b0;
    show_ld  = 1'b0;
    br_ld    = 1'b0;
    wdata_ld = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mar_ld  = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_ld   = 1'b1;
          taken_d = 1'b0;
          state_d = DECODE;
        end
      end

      DECODE: begin
        wdata_ld = 1'b1;
        if (need_mem) begin
          mar_d   = opnd_addr;
          mar_ld  = 1'b1;
          we_d    = is_store;
          state_d = OPER;
        end else begin
          state_d = EXEC;
        end
      end

      OPER: begin
        if (mem_ready) begin
          mdr_ld  = ~we_q;
          we_d    = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (exec_done) begin
          br_ld   = 1'b1;
          taken_d = branch_take;
          show_ld = show_load;
          if (halt) begin
            state_d = IDLE;
          end else begin
            mar_d   = branch_take ? branch_target : eff_pc;
            mar_ld  = 1'b1;
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  assign mem_req   = (state_q == FETCH) || (state_q == OPER);
  assign mem_we    = we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = wdata_q;
  assign exec_req  = (state_q == EXEC);
  assign busy      = (state_q != IDLE);
  assign opcode    = ir_q[DATA_W-1 -: OPC_W];
  assign status    = (|opcode) | ~ir_q[0];
  assign mdr_out   = mdr_q;
  assign show_out  = show_q;
  assign pc_out    = eff_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level driver with an arithmetic model, per-cycle compare.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, start, halt;
  logic       mem_req, mem_we, mem_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] opcode;
  logic [7:0] operand, mdr_out, pc_out, show_out;
  logic       need_mem, is_store, exec_req, exec_done, branch_take, show_load;
  logic [7:0] a_data, branch_target;
  logic       status, busy;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .opcode(opcode), .operand(operand),
    .mdr_out(mdr_out), .pc_out(pc_out), .need_mem(need_mem), .is_store(is_store),
    .a_data(a_data), .exec_req(exec_req), .exec_done(exec_done),
    .branch_take(branch_take), .branch_target(branch_target), .show_load(show_load),
    .show_out(show_out), .status(status), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: plain integers updated once per completed protocol step.
  int m_pc, m_mar, m_ir, m_mdr, m_show, m_wdata;
  int m_busy, m_req, m_we, m_xreq;

  int seen_dec_pc, seen_oper_addr, seen_oper_we, seen_oper_wdata;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_mdr = 0; m_show = 0; m_wdata = 0;
    m_busy = 0; m_req = 0; m_we = 0; m_xreq = 0;
  endtask

  always @(negedge clk) begin
    chk("mem_req",   int'(mem_req),   m_req);
    chk("mem_we",    int'(mem_we),    m_we);
    chk("mem_addr",  int'(mem_addr),  m_mar);
    chk("mem_wdata", int'(mem_wdata), m_wdata);
    chk("opcode",    int'(opcode),    m_ir / 32);
    chk("operand",   int'(operand),   m_ir % 32);
    chk("status",    int'(status),    ((m_ir / 32) != 0 || (m_ir % 2) == 0) ? 1 : 0);
    chk("mdr_out",   int'(mdr_out),   m_mdr);
    chk("pc_out",    int'(pc_out),    m_pc);
    chk("show_out",  int'(show_out),  m_show);
    chk("busy",      int'(busy),      m_busy);
    chk("exec_req",  int'(exec_req),  m_xreq);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'($urandom);
    m_mar = m_pc; m_req = 1; m_busy = 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; mem_ready = 1'($urandom); exec_done = 1'($urandom);
      tick();
    end
  endtask

  // Runs one instruction; entered with the sequencer in its fetch step.
  task automatic run_instr(input logic [7:0] instr, input int fwait,
                           input bit need, input bit store, input logic [7:0] rd,
                           input int owait, input logic [7:0] a, input int xwait,
                           input bit take, input logic [7:0] tgt, input bit shw, input bit hlt);
    for (int i = 0; i < fwait; i++) begin
      mem_ready = 1'b0; mem_rdata = 8'($urandom); exec_done = 1'($urandom);
      start = 1'($urandom);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = instr; exec_done = 1'($urandom);
    tick();
    m_ir = instr; m_pc = (m_pc + 1) % 256; m_req = 0;
    seen_dec_pc = pc_out;

    need_mem = need; is_store = store; a_data = a;
    mem_ready = 1'($urandom); mem_rdata = 8'($urandom); exec_done = 1'($urandom);
    tick();
    need_mem = 1'($urandom); is_store = 1'($urandom); a_data = 8'($urandom);
    m_wdata = a;

    if (need) begin
      m_mar = ((instr % 32) * 8) % 256; m_we = store ? 1 : 0; m_req = 1;
      seen_oper_addr = mem_addr; seen_oper_we = mem_we; seen_oper_wdata = mem_wdata;
      for (int i = 0; i < owait; i++) begin
        mem_ready = 1'b0; mem_rdata = 8'($urandom); exec_done = 1'($urandom);
        tick();
      end
      mem_ready = 1'b1; mem_rdata = rd; exec_done = 1'($urandom);
      tick();
      if (!store) m_mdr = rd;
      m_we = 0; m_req = 0;
    end

    m_xreq = 1;
    for (int i = 0; i < xwait; i++) begin
      exec_done = 1'b0; mem_ready = 1'($urandom); halt = 1'($urandom);
      branch_take = 1'($urandom); branch_target = 8'($urandom); show_load = 1'($urandom);
      tick();
    end
    exec_done = 1'b1; branch_take = take; branch_target = tgt; show_load = shw; halt = hlt;
    tick();
    exec_done = 1'b0; halt = 1'b0; branch_take = 1'($urandom); show_load = 1'($urandom);
    m_xreq = 0;
    if (take) m_pc = tgt;
    if (shw)  m_show = m_mdr;
    if (hlt) begin
      m_busy = 0;
      start  = 1'b0;
    end else begin
      m_mar = m_pc; m_req = 1;
    end
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0; start = 1'b0; halt = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
    need_mem = 1'b0; is_store = 1'b0; a_data = 8'h00; exec_done = 1'b0;
    branch_take = 1'b0; branch_target = 8'h00; show_load = 1'b0;
    tick();
    tick();
    chk("reset_pc", int'(pc_out), 0);
    chk("reset_status", int'(status), 1);
    reset_n = 1'b1;
    idle_cycles(2);

    // Simple fetch of 0x05, no operand, immediate exec_done.
    start_run();
    run_instr(8'h05, 0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 8'h00, 0, 0);
    chk("t1_pc", int'(pc_out), 8'h01);
    chk("t1_addr", int'(mem_addr), 8'h01);
    chk("t1_operand", int'(operand), 8'h05);

    // Operand read at 3<<3, then show the loaded MDR.
    run_instr(8'h23, 0, 1, 0, 8'hAA, 0, 8'h11, 1, 0, 8'h00, 1, 0);
    chk("t2_oper_addr", seen_oper_addr, 8'h18);
    chk("t2_mdr", int'(mdr_out), 8'hAA);
    chk("t2_show", int'(show_out), 8'hAA);
    chk("t2_opcode", int'(opcode), 1);

    // Store of a_data to 5<<3; MDR must keep 0xAA.
    run_instr(8'h45, 0, 1, 1, 8'h77, 1, 8'h5C, 0, 0, 8'h00, 0, 0);
    chk("t3_oper_addr", seen_oper_addr, 8'h28);
    chk("t3_oper_we", seen_oper_we, 1);
    chk("t3_wdata", seen_oper_wdata, 8'h5C);
    chk("t3_mdr", int'(mdr_out), 8'hAA);

    // Four-cycle fetch stall, then branch to 0xFF.
    run_instr(8'h81, 4, 0, 0, 8'h00, 0, 8'h22, 2, 1, 8'hFF, 0, 0);
    chk("t4_addr", int'(mem_addr), 8'hFF);

    // Fetch at 0xFF wraps PC to 0; branch to 0x40 and halt together.
    run_instr(8'h10, 0, 0, 0, 8'h00, 0, 8'h33, 0, 1, 8'h40, 0, 1);
    chk("t5_wrap_pc", seen_dec_pc, 8'h00);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pc", int'(pc_out), 8'h40);
    idle_cycles(3);
    chk("t5_idle_busy", int'(busy), 0);

    // Reset asserted while an operand read is stalled.
    start_run();
    mem_ready = 1'b1; mem_rdata = 8'h23;
    tick();
    m_ir = 8'h23; m_pc = (m_pc + 1) % 256; m_req = 0;
    need_mem = 1'b1; is_store = 1'b0; a_data = 8'h9E; mem_ready = 1'b0;
    tick();
    m_wdata = 8'h9E; m_mar = 8'h18; m_req = 1; m_we = 0;
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_req", int'(mem_req), 0);
    chk("t6_pc", int'(pc_out), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ir", int'(opcode), 0);
    tick();
    reset_n = 1'b1;
    idle_cycles(2);

    // Randomised instruction stream with occasional halt/restart.
    start_run();
    for (int n = 0; n < 80; n++) begin
      bit hlt;
      hlt = ($urandom_range(0, 7) == 0);
      run_instr(8'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                8'($urandom), $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3),
                1'($urandom), 8'($urandom), 1'($urandom), hlt);
      if (hlt) begin
        idle_cycles($urandom_range(0, 3));
        start_run();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
